// File: rtl/call_stack_pkg.sv
// Shared definitions for the return-address stack: PC width, default
// stack depth, PC-select encodings, and the stack operation decode.
package call_stack_pkg;

  localparam int PC_W      = 16;
  localparam int RAS_DEPTH = 8;

  // Next-PC mux select; control pushes on CALL and pops on PC_SEL_RET.
  typedef enum logic [1:0] {
    PC_SEL_INC = 2'b00,
    PC_SEL_BR  = 2'b01,
    PC_SEL_JMP = 2'b10,
    PC_SEL_RET = 2'b11
  } pc_sel_e;

  // Stack operation seen in one cycle after priority resolution.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_REPL  = 3'd3,
    OP_FLUSH = 3'd4
  } stack_op_e;

  // Flush wins over everything; push+pop together becomes a replace.
  function automatic stack_op_e decode_op(input logic push, input logic pop,
                                          input logic flush);
    if (flush)            return OP_FLUSH;
    else if (push && pop) return OP_REPL;
    else if (push)        return OP_PUSH;
    else if (pop)         return OP_POP;
    else                  return OP_NONE;
  endfunction

endpackage

// File: rtl/call_stack_if.sv
// Control-side bundle for the return-address stack.
interface call_stack_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              push;
  logic              pop;
  logic              flush;
  logic [ADDR_W-1:0] push_data;
  logic [ADDR_W-1:0] stack_data;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  // Decode/control side drives requests and observes the stack.
  modport master (
    output push, pop, flush, push_data,
    input  stack_data, count, empty, full, overflow, underflow
  );

  // The stack itself.
  modport slave (
    input  push, pop, flush, push_data,
    output stack_data, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/call_stack_regfile.sv
// DEPTH x ADDR_W storage: one synchronous write port, one async read port.
// Contents are intentionally not reset.
module stack_regfile #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [DEPTH-1:0][ADDR_W-1:0] mem_q, mem_d;

  // Next array contents: single entry overwritten on write enable.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Array storage, no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack. Top of stack is read combinationally so
// the PC mux sees the RET target in the same cycle the pop is decoded.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int DEPTH  = RAS_DEPTH,
  parameter int ADDR_W = PC_W
) (
  input  logic clk,
  input  logic rst,
  call_stack_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0]  sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              is_empty, is_full;
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [IDX_W-1:0]  top_idx;
  logic [ADDR_W-1:0] top_data;
  stack_op_e         op;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == CNT_W'(DEPTH));
  assign top_idx  = IDX_W'(sp_q - CNT_W'(1));
  assign op       = decode_op(bus.push, bus.pop, bus.flush);

  // Pointer, sticky flags and write-port control for this cycle's op.
  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    we    = 1'b0;
    waddr = IDX_W'(sp_q);
    case (op)
      OP_FLUSH: begin
        sp_d  = '0;
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      OP_PUSH: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          we   = 1'b1;
          sp_d = sp_q + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (is_empty) udf_d = 1'b1;
        else          sp_d  = sp_q - CNT_W'(1);
      end
      OP_REPL: begin
        // Empty: the pop half is rejected, the push half still lands at 0.
        we = 1'b1;
        if (is_empty) begin
          udf_d = 1'b1;
          waddr = '0;
          sp_d  = CNT_W'(1);
        end else begin
          waddr = top_idx;
        end
      end
      default: ;
    endcase
  end

  // Pointer and sticky flags; async reset empties the stack immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  stack_regfile #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_regfile (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(bus.push_data),
    .raddr(top_idx),
    .rdata(top_data)
  );

  assign bus.stack_data = is_empty ? '0 : top_data;
  assign bus.count      = sp_q;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = udf_q;

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
Hardware return-address stack that supplies the 16-bit return target to the PC-select stage on RET (pc_sel = 2'b11).
- On CALL, control pushes the return address (current_pc + 1).
- On RET, control pops, and the popped value is presented as the next-PC source.
- Sits beside the PC register, fed by the decode/control unit, and drives stack_data to the next-PC mux.

Parameters:
DEPTH, 8, number of 16-bit return entries; power of two, 2..64
ADDR_W, 16, width of a stored return address (matches PC width)
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
push  input  1  CALL: write push_data as new top-of-stack
pop  input  1  RET: remove current top-of-stack
push_data  input  ADDR_W  return address to store (current_pc + 1, computed by control)
flush  input  1  synchronous clear of the stack (exception/soft reset); wins over push/pop
stack_data  output  ADDR_W  current top-of-stack; 0 when empty
count  output  CNT_W  number of valid entries, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky: push rejected because full
underflow  output  1  sticky: pop requested while empty

Behaviour:
- Storage: DEPTH x ADDR_W register array plus stack pointer sp (= count). Entry sp-1 is the top.
- Reset (rst=1, async): sp=0, overflow=0, underflow=0. The array is not reset. Outputs: stack_data=0, count=0, empty=1, full=0.
- stack_data is combinational from the array at index sp-1, masked to 0 when empty. This gives zero latency: in the cycle RET is decoded, stack_data already holds the address the PC mux selects. The pop takes effect at the same clock edge as the PC update.
- Push only (push=1, pop=0):
  - not full: mem[sp] <= push_data, sp <= sp+1.
  - full: no write, sp unchanged, overflow <= 1.
- Pop only (pop=1, push=0):
  - not empty: sp <= sp-1. The array is unchanged.
  - empty: sp unchanged, underflow <= 1.
- Push and pop in the same cycle:
  - not empty: replace top, i.e. mem[sp-1] <= push_data, sp unchanged. This applies when full too, and no overflow is raised.
  - empty: pop is ignored and underflow <= 1. The push is performed (mem[0] <= push_data, sp <= 1).
- Flush: sp <= 0, overflow <= 0, underflow <= 0, overriding push/pop that cycle. Array contents are don't-care.
- Sticky flags clear only on rst or flush.
- Width rules:
  - sp arithmetic is done in CNT_W bits and never wraps, because it is guarded by the full/empty checks.
  - Index into the array is sp-1 or sp truncated to $clog2(DEPTH) bits.
- Reset mid-operation: any in-flight push/pop is lost. The stack is empty immediately and asynchronously, not at the next edge.

Decomposition:
- Shared include (alongside the opcode definitions): PC_W = 16, RAS_DEPTH default, and the PC-select encodings PC_SEL_INC=2'b00, PC_SEL_BR=2'b01, PC_SEL_JMP=2'b10, PC_SEL_RET=2'b11. Control uses these to drive push on CALL and pop on PC_SEL_RET.
- One natural sub-module, stack_regfile: DEPTH x ADDR_W array with one synchronous write port and one async read port. The pointer/flag logic stays in call_stack.

Test Plan:
- Reset then idle -> stack_data=0x0000, count=0, empty=1, full=0, overflow=0, underflow=0. Assert rst mid-sequence after 3 pushes -> count=0 and empty=1 before the next clk edge.
- Push 0x0011, 0x0022, 0x0033 on consecutive cycles -> count=3, stack_data=0x0033. Pop three times -> stack_data shows 0x0022, then 0x0011, then 0x0000, with empty=1 after the third pop.
- DEPTH=8: push 0x0100..0x0107 -> full=1, stack_data=0x0107. Ninth push of 0x0FFF -> overflow=1, count=8, stack_data=0x0107 still.
- Pop with empty=1 -> underflow=1, count=0. Apply flush -> underflow=0, overflow=0.
- Push+pop same cycle with top=0x0022 and push_data=0x0055 -> count unchanged, stack_data=0x0055, previous entry 0x0011 intact after a subsequent pop. Repeat when full -> no overflow. Repeat when empty -> count=1, stack_data=0x0055, underflow=1.
- Flush asserted together with push=1 of 0x0077 at count=4 -> count=0, empty=1, stack_data=0x0000, no entry written.
